// File: rtl/timer_ctrl.sv
// timer_ctrl: prescaled up-counter with one-shot / periodic modes.
// States: IDLE -> RUN -> (PAUSE <-> RUN) -> DONE (one-shot) or loop in RUN (periodic).
// Configuration (mode, period, prescale) is captured only when a run is launched
// from IDLE or DONE, so the live inputs may change freely during a run.
//
// Control inputs are plain levels sampled on every rising clk edge; there is no
// valid/ready handshake. When several are high together, clr beats stop, and stop
// beats start. The current FSM state is exported on the state port for checkers.
module timer_ctrl #(
  parameter int WIDTH = 4,
  parameter int PW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clr,
  input  logic             mode,
  input  logic [WIDTH-1:0] period,
  input  logic [PW-1:0]    prescale,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             busy,
  output logic             done,
  output logic             tick,
  output logic             err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             cfg_mode_q, cfg_mode_d;
  logic [WIDTH-1:0] cfg_period_q, cfg_period_d;
  logic [PW-1:0]    cfg_presc_q, cfg_presc_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  // Launch request: start accepted (stop not asserted) from IDLE or DONE.
  logic launch;
  // Launch request whose period is non-zero; a zero period is rejected with err.
  logic launch_ok;

  always_comb begin
    launch    = 1'b0;
    launch_ok = 1'b0;
    if (!clr && !stop && start && (state_q == ST_IDLE || state_q == ST_DONE)) begin
      launch    = 1'b1;
      launch_ok = (period != '0);
    end
  end

  // Next-state and datapath: hold by default, then apply clr > stop > start.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    presc_d      = presc_q;
    cfg_mode_d   = cfg_mode_q;
    cfg_period_d = cfg_period_q;
    cfg_presc_d  = cfg_presc_q;
    tick_d       = 1'b0;
    err_d        = 1'b0;

    if (clr) begin
      state_d = ST_IDLE;
      count_d = '0;
      presc_d = '0;
    end else if (launch) begin
      if (launch_ok) begin
        // Fresh run: capture the configuration and restart both counters.
        state_d      = ST_RUN;
        count_d      = '0;
        presc_d      = '0;
        cfg_mode_d   = mode;
        cfg_period_d = period;
        cfg_presc_d  = prescale;
      end else begin
        // Rejected start leaves state and count untouched (DONE keeps P).
        err_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (stop) begin
            // Freeze both counters; this edge neither advances nor ticks.
            state_d = ST_PAUSE;
          end else if (presc_q == cfg_presc_q) begin
            // Advance enable: prescaler wraps and the count moves.
            presc_d = '0;
            if (count_q == cfg_period_q) begin
              tick_d = 1'b1;
              if (cfg_mode_q) begin
                count_d = '0;
              end else begin
                state_d = ST_DONE;
              end
            end else begin
              // count < P here, so the increment can never wrap.
              count_d = count_q + WIDTH'(1);
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        ST_PAUSE: begin
          // Resume exactly where the run was frozen; no reload.
          if (!stop && start) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          // IDLE and DONE hold unless a launch was handled above.
          state_d = state_q;
        end
      endcase
    end
  end

  // State, counters, captured configuration and the registered pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      presc_q      <= '0;
      cfg_mode_q   <= 1'b0;
      cfg_period_q <= '0;
      cfg_presc_q  <= '0;
      tick_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      presc_q      <= presc_d;
      cfg_mode_q   <= cfg_mode_d;
      cfg_period_q <= cfg_period_d;
      cfg_presc_q  <= cfg_presc_d;
      tick_q       <= tick_d;
      err_q        <= err_d;
    end
  end

  // Status outputs decoded straight from the registered state.
  always_comb begin
    state = state_q;
    count = count_q;
    busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    done  = (state_q == ST_DONE);
    tick  = tick_q;
    err   = err_q;
  end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the count/period width in bits.
REQ-002 SHALL have parameter PW, default 4, giving the prescale width in bits.
REQ-003 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  launch a new run (IDLE/DONE) or resume (PAUSE).
REQ-006 SHALL have port stop  input  1  pause a run.
REQ-007 SHALL have port clr  input  1  synchronous abort to IDLE.
REQ-008 SHALL have port mode  input  1  0 = one-shot, 1 = periodic.
REQ-009 SHALL have port period  input  WIDTH  terminal count P.
REQ-010 SHALL have port prescale  input  PW  divider S; count advances every S+1 cycles.
REQ-011 SHALL have port count  output  WIDTH  current count value.
REQ-012 SHALL have port state  output  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-013 SHALL have port busy  output  1  high in RUN and PAUSE.
REQ-014 SHALL have port done  output  1  high in DONE.
REQ-015 SHALL have port tick  output  1  one-cycle registered pulse per terminal event.
REQ-016 SHALL have port err  output  1  one-cycle registered pulse on a rejected start.

Function
REQ-017 SHALL apply input priority clr > stop > start in every state.
REQ-018 SHALL latch mode, period and prescale only on an accepted start from IDLE or DONE; input changes at any other time SHALL be ignored.
REQ-019 IDLE: count=0; start with period!=0 -> RUN with count=0 and prescaler=0; start with period==0 -> stay IDLE, err=1 for one cycle.
REQ-020 RUN: prescaler increments each cycle; when prescaler==S it wraps to 0 and count advances (an advance enable).
REQ-021 RUN: an advance with count<P SHALL increment count by 1.
REQ-022 RUN: an advance with count==P is the terminal event, and tick SHALL be 1 in the following cycle only.
REQ-023 On the terminal event, periodic mode SHALL set count=0 and stay in RUN; one-shot mode SHALL hold count=P and enter DONE.
REQ-024 Tick spacing in periodic mode SHALL be exactly (P+1)*(S+1) cycles; each count value SHALL persist S+1 cycles.
REQ-025 RUN + stop -> PAUSE, freezing count and prescaler; no advance and no tick on that edge.
REQ-026 PAUSE + start -> RUN, resuming from the frozen count and prescaler with no reload; PAUSE + stop -> no change.
REQ-027 DONE: count holds P; start -> reload per REQ-018/REQ-019 and enter RUN (or stay in DONE with err if period==0); stop -> no change.
REQ-028 clr in any state SHALL give IDLE with count=0 and prescaler=0 on the next edge, and no tick.
REQ-029 Count SHALL never exceed P; WIDTH-bit arithmetic only, with no wrap past 2^WIDTH-1 (P=2^WIDTH-1 is legal).
REQ-030 SHALL cover all four state encodings; no unreachable state.

Reset
REQ-031 While rst=0, regardless of clk: state=IDLE, count=0, prescaler=0, busy=0, done=0, tick=0, err=0, and latched config=0.
REQ-032 Assertion of rst mid-run SHALL abort immediately; after release the block SHALL require a new start.

Verification
REQ-033 One-shot, P=3, S=0, start at edge k -> count 1,2,3 at edges k+1..k+3; tick=1 only after edge k+4; state=DONE, done=1, count=3 held.
REQ-034 Periodic, P=2, S=1 -> count sequence 0,0,1,1,2,2,0,...; tick every 6 cycles for at least 3 periods; busy=1 throughout.
REQ-035 Periodic, P=5, S=0; stop at count=2 and hold 5 cycles, then start -> state=PAUSE with count=2 frozen, then resume 3,4,5 with no reload.
REQ-036 Start with period=0 in IDLE -> err single-cycle pulse; state stays IDLE; count=0.
REQ-037 In RUN, start and stop on the same edge -> PAUSE; then clr -> IDLE, count=0, busy=0.
REQ-038 rst low mid-run at count=4 (P=7), asynchronous to clk -> outputs reach their reset values before the next clk edge; after release the block stays in IDLE until start.
